// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit:
// opcodes, condition codes, NZCV indices, flag-write bits.
package ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // flagWrite[FW_NZ] guards N/Z, flagWrite[FW_CV] guards C/V
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: instruction fields and hazard inputs
// from the datapath (master), decoded controls back (slave).
interface pipelined_control_unit_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_ADDR_W = 4
);
  logic [1:0]            op_d;
  logic [5:0]            funct_d;
  logic [3:0]            cond_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic [3:0]            alu_flags_e;
  logic                  flush_e;

  logic [1:0]            imm_src_d;
  logic [1:0]            reg_src_d;
  logic [ALU_CTRL_W-1:0] alu_control_e;
  logic                  alu_src_e;
  logic                  mov_imm_e;
  logic                  branch_taken_e;
  logic                  mem_write_m;
  logic                  reg_write_w;
  logic [1:0]            result_src_w;
  logic                  reg_data_src_w;
  logic                  dest_src_w;
  logic                  pc_write_w;
  logic [3:0]            flags_q;

  modport master (
    output op_d, funct_d, cond_d, rd_d,
    output alu_flags_e, flush_e,
    input  imm_src_d, reg_src_d,
    input  alu_control_e, alu_src_e,
    input  mov_imm_e, branch_taken_e,
    input  mem_write_m, reg_write_w,
    input  result_src_w, reg_data_src_w,
    input  dest_src_w, pc_write_w, flags_q
  );

  modport slave (
    input  op_d, funct_d, cond_d, rd_d,
    input  alu_flags_e, flush_e,
    output imm_src_d, reg_src_d,
    output alu_control_e, alu_src_e,
    output mov_imm_e, branch_taken_e,
    output mem_write_m, reg_write_w,
    output result_src_w, reg_data_src_w,
    output dest_src_w, pc_write_w, flags_q
  );
endinterface

// File: rtl/pipelined_control_unit_cond_check.sv
// Condition-field evaluator against NZCV.
// COND_EXEC_EN undefined: every instruction executes.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condEx
);
`ifdef COND_EXEC_EN
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condEx = 1'b0;
    unique case (cond)
      COND_EQ: condEx = z;
      COND_NE: condEx = ~z;
      COND_CS: condEx = c;
      COND_CC: condEx = ~c;
      COND_MI: condEx = n;
      COND_PL: condEx = ~n;
      COND_VS: condEx = v;
      COND_VC: condEx = ~v;
      COND_HI: condEx = c & ~z;
      COND_LS: condEx = ~c | z;
      COND_GE: condEx = (n == v);
      COND_LT: condEx = (n != v);
      COND_GT: condEx = ~z & (n == v);
      COND_LE: condEx = z | (n != v);
      COND_AL: condEx = 1'b1;
      COND_NV: condEx = 1'b0;
      default: condEx = 1'b0;
    endcase
  end
`else
  logic unusedIn;

  assign unusedIn = ^{cond, flags};
  assign condEx   = 1'b1;
`endif
endmodule

// File: rtl/pipelined_control_unit.sv
// D-stage decode, E/M/W control pipeline and NZCV register.
// COND_EXEC_EN enables conditional execution in Execute.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_ADDR_W = 4
) (
  input logic clk,
  input logic reset_n,
  pipelined_control_unit_if.slave bus
);

  typedef struct packed {
    logic                  regWrite;
    logic                  memWrite;
    logic                  branch;
    logic [1:0]            flagWrite;
    logic [1:0]            resultSrc;
    logic [ALU_CTRL_W-1:0] aluControl;
    logic                  aluSrc;
    logic                  movImm;
    logic                  regDataSrc;
    logic                  destSrc;
    logic [3:0]            cond;
    logic [REG_ADDR_W-1:0] rd;
  } idEx_t;

  typedef struct packed {
    logic                  regWrite;
    logic                  memWrite;
    logic [1:0]            resultSrc;
    logic                  regDataSrc;
    logic                  destSrc;
    logic [REG_ADDR_W-1:0] rd;
  } exMem_t;

  typedef struct packed {
    logic                  regWrite;
    logic [1:0]            resultSrc;
    logic                  regDataSrc;
    logic                  destSrc;
    logic [REG_ADDR_W-1:0] rd;
  } memWb_t;

  logic [1:0] op;
  logic [5:0] f;
  logic       isDp, isMem, isBr, bx;
  logic       fwCv;
  idEx_t      dec, exQ;
  exMem_t     memD, memQ;
  memWb_t     wbQ;
  logic [3:0] flagsQ;
  logic       condEx;

  assign op    = bus.op_d;
  assign f     = bus.funct_d;
  assign isDp  = (op == OP_DP);
  assign isMem = (op == OP_MEM);
  assign isBr  = (op == OP_BR);
  assign bx    = isDp & (f == 6'b010010);
  assign fwCv  = (f[4:1] == 4'd2)
               | (f[4:1] == 4'd4)
               | (f[4:1] == 4'd10);

  assign bus.imm_src_d = op;
  assign bus.reg_src_d = {isBr, isMem};

  always_comb begin
    dec            = '0;
    dec.cond       = bus.cond_d;
    dec.rd         = bus.rd_d;
    dec.aluControl = ALU_CTRL_W'(4'b0100);
    dec.aluSrc     = 1'b1;
    unique case (1'b1)
      isDp: begin
        dec.regWrite = (~f[5] & (f[4:1] != 4'b1010))
                     | (f == 6'b111010);
        dec.branch     = bx;
        dec.resultSrc  = {bx, bx};
        dec.aluControl = ALU_CTRL_W'(f[4:1]);
        dec.aluSrc     = 1'b0;
        dec.movImm     = f[5];
        dec.flagWrite[FW_NZ] = f[0];
        dec.flagWrite[FW_CV] = f[0] & fwCv;
      end
      isMem: begin
        dec.regWrite  = f[0];
        dec.memWrite  = ~f[0];
        dec.resultSrc = 2'b01;
      end
      isBr: begin
        dec.regWrite   = f[4];
        dec.branch     = f[5];
        dec.regDataSrc = f[4];
        dec.destSrc    = 1'b1;
      end
      default: ;
    endcase
  end

  // a flush turns the incoming slot into an all-zero bubble
  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush_e) exQ <= '0;
    else                         exQ <= dec;
  end

  cond_check u_condCheck (
    .cond   (exQ.cond),
    .flags  (flagsQ),
    .condEx (condEx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flagsQ <= '0;
    end else begin
      if (exQ.flagWrite[FW_NZ] && condEx)
        flagsQ[FLAG_N:FLAG_Z] <=
          bus.alu_flags_e[FLAG_N:FLAG_Z];
      if (exQ.flagWrite[FW_CV] && condEx)
        flagsQ[FLAG_C:FLAG_V] <=
          bus.alu_flags_e[FLAG_C:FLAG_V];
    end
  end

  always_comb begin
    memD            = '0;
    memD.regWrite   = exQ.regWrite & condEx;
    memD.memWrite   = exQ.memWrite & condEx;
    memD.resultSrc  = exQ.resultSrc;
    memD.regDataSrc = exQ.regDataSrc;
    memD.destSrc    = exQ.destSrc;
    memD.rd         = exQ.rd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      memQ           <= memD;
      wbQ.regWrite   <= memQ.regWrite;
      wbQ.resultSrc  <= memQ.resultSrc;
      wbQ.regDataSrc <= memQ.regDataSrc;
      wbQ.destSrc    <= memQ.destSrc;
      wbQ.rd         <= memQ.rd;
    end
  end

  assign bus.alu_control_e  = exQ.aluControl;
  assign bus.alu_src_e      = exQ.aluSrc;
  assign bus.mov_imm_e      = exQ.movImm;
  assign bus.branch_taken_e = exQ.branch & condEx;
  assign bus.mem_write_m    = memQ.memWrite;
  assign bus.reg_write_w    = wbQ.regWrite;
  assign bus.result_src_w   = wbQ.resultSrc;
  assign bus.reg_data_src_w = wbQ.regDataSrc;
  assign bus.dest_src_w     = wbQ.destSrc;
  assign bus.pc_write_w     = wbQ.regWrite & (&wbQ.rd);
  assign bus.flags_q        = flagsQ;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed vectors for pipelined_control_unit:
// decode table, pipeline latency, flags, flush, reset.
module tb_pipelined_control_unit;

`ifdef COND_EXEC_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(
    .ALU_CTRL_W(4),
    .REG_ADDR_W(4)
  ) bus ();

  pipelined_control_unit #(
    .ALU_CTRL_W(4),
    .REG_ADDR_W(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    logic [3:0] alf;
    logic [1:0] imm;
    logic [1:0] rsrc;
    logic [3:0] alu;
    logic       asrc;
    logic       mov;
    logic       br;
    logic       mw;
    logic       rw;
    logic [1:0] res;
    logic       rds;
    logic       dst;
    logic       pcw;
    logic [3:0] flg;
  } vec_t;

  vec_t tbl[13];
  int nVec  = 0;
  int nFail = 0;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setD(input logic [1:0] op,
                      input logic [5:0] f,
                      input logic [3:0] c,
                      input logic [3:0] rd);
    bus.op_d    = op;
    bus.funct_d = f;
    bus.cond_d  = c;
    bus.rd_d    = rd;
  endtask

  // CMP without S: no write, no flags, no branch
  task automatic nop();
    setD(2'b00, 6'b010100, 4'hE, 4'h0);
  endtask

  initial begin
    tbl[0]  = '{2'b00, 6'b001000, 4'd1,  4'b1111,
                2'b00, 2'b00, 4'b0100, 0, 0, 0, 0, 1,
                2'b00, 0, 0, 0, 4'b0000};
    tbl[1]  = '{2'b00, 6'b000101, 4'd2,  4'b0100,
                2'b00, 2'b00, 4'b0010, 0, 0, 0, 0, 1,
                2'b00, 0, 0, 0, 4'b0100};
    tbl[2]  = '{2'b00, 6'b010101, 4'd0,  4'b1001,
                2'b00, 2'b00, 4'b1010, 0, 0, 0, 0, 0,
                2'b00, 0, 0, 0, 4'b1001};
    tbl[3]  = '{2'b00, 6'b000001, 4'd3,  4'b0110,
                2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 1,
                2'b00, 0, 0, 0, 4'b0101};
    tbl[4]  = '{2'b00, 6'b111010, 4'd4,  4'b1111,
                2'b00, 2'b00, 4'b1101, 0, 1, 0, 0, 1,
                2'b00, 0, 0, 0, 4'b0101};
    tbl[5]  = '{2'b01, 6'b011001, 4'd5,  4'b1111,
                2'b01, 2'b01, 4'b0100, 1, 0, 0, 0, 1,
                2'b01, 0, 0, 0, 4'b0101};
    tbl[6]  = '{2'b01, 6'b011000, 4'd6,  4'b1111,
                2'b01, 2'b01, 4'b0100, 1, 0, 0, 1, 0,
                2'b01, 0, 0, 0, 4'b0101};
    tbl[7]  = '{2'b10, 6'b100000, 4'd0,  4'b1111,
                2'b10, 2'b10, 4'b0100, 1, 0, 1, 0, 0,
                2'b00, 0, 1, 0, 4'b0101};
    tbl[8]  = '{2'b10, 6'b110000, 4'd14, 4'b1111,
                2'b10, 2'b10, 4'b0100, 1, 0, 1, 0, 1,
                2'b00, 1, 1, 0, 4'b0101};
    tbl[9]  = '{2'b00, 6'b010010, 4'd15, 4'b1111,
                2'b00, 2'b00, 4'b1001, 0, 0, 1, 0, 1,
                2'b11, 0, 0, 1, 4'b0101};
    tbl[10] = '{2'b00, 6'b001000, 4'd15, 4'b1111,
                2'b00, 2'b00, 4'b0100, 0, 0, 0, 0, 1,
                2'b00, 0, 0, 1, 4'b0101};
    tbl[11] = '{2'b00, 6'b010100, 4'd15, 4'b1111,
                2'b00, 2'b00, 4'b1010, 0, 0, 0, 0, 0,
                2'b00, 0, 0, 0, 4'b0101};
    tbl[12] = '{2'b00, 6'b001001, 4'd7,  4'b1010,
                2'b00, 2'b00, 4'b0100, 0, 0, 0, 0, 1,
                2'b00, 0, 0, 0, 4'b1010};

    reset_n         = 1'b0;
    bus.flush_e     = 1'b0;
    bus.alu_flags_e = 4'h0;
    nop();
    repeat (3) tick();
    reset_n = 1'b1;

    chk("rst_rw",    8'(bus.reg_write_w), 8'h0);
    chk("rst_mw",    8'(bus.mem_write_m), 8'h0);
    chk("rst_flags", 8'(bus.flags_q), 8'h0);
    chk("rst_alu",   8'(bus.alu_control_e), 8'h0);
    chk("rst_br",    8'(bus.branch_taken_e), 8'h0);

    // ADD R1: reg_write_w rises exactly 3 edges later
    setD(2'b00, 6'b001000, 4'hE, 4'd1);
    tick();
    chk("add_alu_e", 8'(bus.alu_control_e), 8'h4);
    chk("add_rw_c1", 8'(bus.reg_write_w), 8'h0);
    nop();
    tick();
    chk("add_rw_c2", 8'(bus.reg_write_w), 8'h0);
    tick();
    chk("add_rw_c3", 8'(bus.reg_write_w), 8'h1);
    tick();
    chk("add_rw_c4", 8'(bus.reg_write_w), 8'h0);

    for (int i = 0; i < 13; i++) begin
      bus.flush_e     = 1'b0;
      bus.alu_flags_e = tbl[i].alf;
      setD(tbl[i].op, tbl[i].f, 4'hE, tbl[i].rd);
      #1;
      chk($sformatf("v%0d_imm", i),
          8'(bus.imm_src_d), 8'(tbl[i].imm));
      chk($sformatf("v%0d_rsrc", i),
          8'(bus.reg_src_d), 8'(tbl[i].rsrc));
      tick();
      chk($sformatf("v%0d_alu", i),
          8'(bus.alu_control_e), 8'(tbl[i].alu));
      chk($sformatf("v%0d_asrc", i),
          8'(bus.alu_src_e), 8'(tbl[i].asrc));
      chk($sformatf("v%0d_mov", i),
          8'(bus.mov_imm_e), 8'(tbl[i].mov));
      chk($sformatf("v%0d_br", i),
          8'(bus.branch_taken_e), 8'(tbl[i].br));
      bus.flush_e = 1'b1;
      nop();
      tick();
      chk($sformatf("v%0d_mw", i),
          8'(bus.mem_write_m), 8'(tbl[i].mw));
      chk($sformatf("v%0d_flags", i),
          8'(bus.flags_q), 8'(tbl[i].flg));
      tick();
      chk($sformatf("v%0d_rw", i),
          8'(bus.reg_write_w), 8'(tbl[i].rw));
      chk($sformatf("v%0d_res", i),
          8'(bus.result_src_w), 8'(tbl[i].res));
      chk($sformatf("v%0d_rds", i),
          8'(bus.reg_data_src_w), 8'(tbl[i].rds));
      chk($sformatf("v%0d_dst", i),
          8'(bus.dest_src_w), 8'(tbl[i].dst));
      chk($sformatf("v%0d_pcw", i),
          8'(bus.pc_write_w), 8'(tbl[i].pcw));
    end
    bus.flush_e = 1'b0;

    // SUBS sets Z, then BEQ / BNE / STRNE / B-NV
    bus.alu_flags_e = 4'b0100;
    setD(2'b00, 6'b000101, 4'hE, 4'd2);
    tick();
    setD(2'b10, 6'b100000, 4'h0, 4'd0);
    tick();
    chk("subs_flags", 8'(bus.flags_q), 8'h4);
    chk("beq_taken", 8'(bus.branch_taken_e), 8'h1);
    setD(2'b10, 6'b100000, 4'h1, 4'd0);
    tick();
    chk("bne_taken", 8'(bus.branch_taken_e),
        CE ? 8'h0 : 8'h1);
    setD(2'b01, 6'b011000, 4'h1, 4'd6);
    tick();
    setD(2'b10, 6'b100000, 4'hF, 4'd0);
    tick();
    chk("strne_mw", 8'(bus.mem_write_m),
        CE ? 8'h0 : 8'h1);
    chk("bnv_taken", 8'(bus.branch_taken_e),
        CE ? 8'h0 : 8'h1);
    nop();
    tick();

    // flush with LDR in D leaves a bubble in E and W
    setD(2'b01, 6'b011001, 4'hE, 4'd5);
    bus.flush_e = 1'b1;
    tick();
    chk("fl_asrc", 8'(bus.alu_src_e), 8'h0);
    chk("fl_alu",  8'(bus.alu_control_e), 8'h0);
    bus.flush_e = 1'b0;
    nop();
    tick();
    tick();
    chk("fl_rw",  8'(bus.reg_write_w), 8'h0);
    chk("fl_res", 8'(bus.result_src_w), 8'h0);

    // flush does not cancel a flag write already in E
    bus.alu_flags_e = 4'b1000;
    setD(2'b00, 6'b000101, 4'hE, 4'd2);
    tick();
    bus.flush_e = 1'b1;
    nop();
    tick();
    chk("fl_flags", 8'(bus.flags_q), 8'h8);
    bus.flush_e = 1'b0;

    // BX, then reset with BX/STR/ADD in flight
    setD(2'b00, 6'b010010, 4'hE, 4'd15);
    tick();
    chk("bx_taken", 8'(bus.branch_taken_e), 8'h1);
    setD(2'b01, 6'b011000, 4'hE, 4'd6);
    tick();
    setD(2'b00, 6'b001000, 4'hE, 4'd1);
    tick();
    chk("bx_res", 8'(bus.result_src_w), 8'h3);
    chk("bx_pcw", 8'(bus.pc_write_w), 8'h1);
    chk("str_mw", 8'(bus.mem_write_m), 8'h1);
    reset_n = 1'b0;
    tick();
    chk("mr_rw",    8'(bus.reg_write_w), 8'h0);
    chk("mr_res",   8'(bus.result_src_w), 8'h0);
    chk("mr_pcw",   8'(bus.pc_write_w), 8'h0);
    chk("mr_mw",    8'(bus.mem_write_m), 8'h0);
    chk("mr_alu",   8'(bus.alu_control_e), 8'h0);
    chk("mr_br",    8'(bus.branch_taken_e), 8'h0);
    chk("mr_flags", 8'(bus.flags_q), 8'h0);
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nFail);
    $finish;
  end

endmodule
